// File: rtl/ppu_exch_pkg.sv
// ppu_exch_pkg
// Shared types for the PPU halo-exchange controller: neighbor direction,
// controller state, the halo FIFO entry, and a direction-to-strobe helper.
// Halo coordinates are stored at COORD_MAX_W bits; the controller uses only
// the low $clog2(TILE_SIZE) bits.

package ppu_exch_pkg;

  localparam int NEIGHBOR_COUNT = 8;
  localparam int COORD_MAX_W    = 16;

  typedef enum logic [2:0] {
    DIR_N  = 3'd0,
    DIR_NE = 3'd1,
    DIR_E  = 3'd2,
    DIR_SE = 3'd3,
    DIR_S  = 3'd4,
    DIR_SW = 3'd5,
    DIR_W  = 3'd6,
    DIR_NW = 3'd7
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CTS = 2'd1,
    ST_SEND     = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef struct packed {
    dir_e                   dir;
    logic [COORD_MAX_W-1:0] row;
    logic [COORD_MAX_W-1:0] column;
    logic [7:0]             value;
  } halo_entry_t;

  function automatic logic [NEIGHBOR_COUNT-1:0] dir_onehot(input dir_e d);
    logic [NEIGHBOR_COUNT-1:0] v;
    v    = '0;
    v[d] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/ppu_exchange_ctrl_fifo.sv
// halo_fifo
// Synchronous FIFO of halo entries. Head is presented combinationally
// (first-word fall-through). A push while full is accepted only when a pop
// happens in the same cycle; otherwise it is dropped and o_drop pulses.
// i_flush empties the FIFO on the next edge (same effect as i_reset).
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_flush               synchronous empty request
//   i_push, i_push_entry  write side
//   i_pop, o_head         read side (pop ignored when empty)
//   o_count               occupancy, 0..DEPTH
//   o_full, o_empty       occupancy flags
//   o_drop                push lost because the FIFO was full

module halo_fifo
  import ppu_exch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  halo_entry_t   i_push_entry,
  input  logic          i_pop,
  output halo_entry_t   o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop
);

  halo_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_drop    = i_push && !w_push_ok;

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_reset && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ppu_exchange_ctrl.sv
// ppu_exchange_ctrl
// Sequences one PPU's halo exchange with its 8 neighbors: collects halo
// entries in a FIFO, runs the clear-to-send / exchange-done handshake after
// the local compute cycle, and drains the entries present at handshake time
// onto the per-neighbor write ports (one entry per cycle, 1-cycle latency).
//
// Optional build macro: PPU_EXCHANGE_TIMEOUT_EN adds a watchdog over the
// WAIT_CTS and DONE states; on expiry it sets o_timeout (sticky), flushes the
// FIFO and returns to IDLE without a group_done pulse. Without the macro
// o_timeout is tied to 0.
//
// Ports:
//   i_clk, i_reset                      clock, synchronous active-high reset
//   i_cycle_done                        local compute finished (pulse)
//   i_halo_push/dir/row/column/value    halo FIFO write side
//   o_halo_full                         FIFO full
//   i_neighbor_cts                      per-neighbor clear-to-send
//   i_neighbor_exchange_done            per-neighbor exchange finished
//   o_clear_to_send, o_exchange_done    this PPU's handshake outputs
//   o_neighbor_output_*                 per-neighbor data lanes and strobes
//   o_busy                              state != IDLE
//   o_group_done                        pulse on DONE -> IDLE
//   o_overflow                          sticky, a push was dropped
//   o_timeout                           sticky, watchdog expired
//
// State table:
//   IDLE     | waiting for i_cycle_done
//   WAIT_CTS | clear_to_send up, waiting for all 8 neighbor CTS
//   SEND     | popping the snapshotted number of entries
//   DONE     | exchange_done up, waiting for all 8 neighbors to finish

module ppu_exchange_ctrl
  import ppu_exch_pkg::*;
#(
  parameter int TILE_SIZE      = 256,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int RW = $clog2(TILE_SIZE),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_cycle_done,
  input  logic                                i_halo_push,
  input  logic [2:0]                          i_halo_dir,
  input  logic [RW-1:0]                       i_halo_row,
  input  logic [RW-1:0]                       i_halo_column,
  input  logic [7:0]                          i_halo_value,
  output logic                                o_halo_full,
  input  logic [NEIGHBOR_COUNT-1:0]           i_neighbor_cts,
  input  logic [NEIGHBOR_COUNT-1:0]           i_neighbor_exchange_done,
  output logic                                o_clear_to_send,
  output logic                                o_exchange_done,
  output logic [NEIGHBOR_COUNT-1:0][7:0]      o_neighbor_output_value,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]   o_neighbor_output_row,
  output logic [NEIGHBOR_COUNT-1:0][RW-1:0]   o_neighbor_output_column,
  output logic [NEIGHBOR_COUNT-1:0]           o_neighbor_output_write_enable,
  output logic                                o_busy,
  output logic                                o_group_done,
  output logic                                o_overflow,
  output logic                                o_timeout
);

  state_e                           r_state;
  state_e                           w_state_nxt;
  logic [CW-1:0]                    r_drain_cnt;
  logic [CW-1:0]                    w_drain_nxt;
  logic                             w_pop;
  logic                             w_flush;
  logic                             w_wd_hit;
  logic                             w_cts;
  logic                             w_exch_done;
  logic                             w_group_done;

  halo_entry_t                      w_push_entry;
  halo_entry_t                      w_head;
  logic [CW-1:0]                    w_count;
  logic                             w_full;
  logic                             w_empty;
  logic                             w_drop;

  logic                             r_overflow;
  logic [NEIGHBOR_COUNT-1:0]        r_we;
  logic [NEIGHBOR_COUNT-1:0][7:0]   r_val;
  logic [NEIGHBOR_COUNT-1:0][RW-1:0] r_row;
  logic [NEIGHBOR_COUNT-1:0][RW-1:0] r_col;

  logic                             w_unused_head;

  always_comb begin
    w_push_entry                   = '0;
    w_push_entry.dir               = dir_e'(i_halo_dir);
    w_push_entry.row[RW-1:0]       = i_halo_row;
    w_push_entry.column[RW-1:0]    = i_halo_column;
    w_push_entry.value             = i_halo_value;
  end

  halo_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_halo_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (w_flush),
    .i_push       (i_halo_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_drop       (w_drop)
  );

  // Upper coordinate bits are always zero for this tile size.
  assign w_unused_head = ^{w_head.row, w_head.column, w_empty};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_nxt  = r_drain_cnt;
    w_pop        = 1'b0;
    w_flush      = 1'b0;
    w_cts        = 1'b0;
    w_exch_done  = 1'b0;
    w_group_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cycle_done) w_state_nxt = ST_WAIT_CTS;
      end
      ST_WAIT_CTS: begin
        w_cts = 1'b1;
        if (i_neighbor_cts == '1) begin
          // Only entries present now belong to this round.
          w_drain_nxt = w_count;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_cts = 1'b1;
        if (r_drain_cnt != '0) begin
          w_pop       = 1'b1;
          w_drain_nxt = r_drain_cnt - CW'(1);
        end
        // Leave with the last pop so its strobe lands in the first DONE cycle.
        if (r_drain_cnt <= CW'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_exch_done = 1'b1;
        if (i_neighbor_exchange_done == '1) begin
          w_state_nxt  = ST_IDLE;
          w_group_done = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_wd_hit) begin
      w_state_nxt  = ST_IDLE;
      w_drain_nxt  = '0;
      w_pop        = 1'b0;
      w_flush      = 1'b1;
      w_group_done = 1'b0;
    end
  end

`ifdef PPU_EXCHANGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout;
  logic            w_wd_active;

  assign w_wd_active = (r_state == ST_WAIT_CTS) || (r_state == ST_DONE);
  assign w_wd_hit    = w_wd_active && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_wd_cnt <= '0;
      else if (w_wd_active)       r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (w_wd_hit) r_timeout <= 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_cfg;

  assign w_wd_hit     = 1'b0;
  assign o_timeout    = 1'b0;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
      r_we       <= '0;
      r_val      <= '0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      r_we <= '0;
      if (w_pop) begin
        r_we                <= dir_onehot(w_head.dir);
        r_val[w_head.dir]   <= w_head.value;
        r_row[w_head.dir]   <= w_head.row[RW-1:0];
        r_col[w_head.dir]   <= w_head.column[RW-1:0];
      end
    end
  end

  assign o_halo_full                    = w_full;
  assign o_clear_to_send                = w_cts;
  assign o_exchange_done                = w_exch_done;
  assign o_group_done                   = w_group_done;
  assign o_busy                         = (r_state != ST_IDLE);
  assign o_overflow                     = r_overflow;
  assign o_neighbor_output_write_enable = r_we;
  assign o_neighbor_output_value        = r_val;
  assign o_neighbor_output_row          = r_row;
  assign o_neighbor_output_column       = r_col;

endmodule

// File: tb/tb_ppu_exchange_ctrl.sv
// tb_ppu_exchange_ctrl
// Directed bench for ppu_exchange_ctrl with hand-computed expectations.
// Build with PPU_EXCHANGE_TIMEOUT_EN to exercise the watchdog at 8 cycles.

module tb_ppu_exchange_ctrl;

  localparam int RW = 8;
`ifdef PPU_EXCHANGE_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1024;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cycle_done;
  logic              halo_push;
  logic [2:0]        halo_dir;
  logic [RW-1:0]     halo_row;
  logic [RW-1:0]     halo_column;
  logic [7:0]        halo_value;
  logic              halo_full;
  logic [7:0]        cts_in;
  logic [7:0]        ned_in;
  logic              cts_out;
  logic              exch_done;
  logic [7:0][7:0]   out_val;
  logic [7:0][RW-1:0] out_row;
  logic [7:0][RW-1:0] out_col;
  logic [7:0]        we;
  logic              busy;
  logic              group_done;
  logic              overflow;
  logic              timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ppu_exchange_ctrl #(
    .TILE_SIZE      (256),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) u_dut (
    .i_clk                          (clk),
    .i_reset                        (reset),
    .i_cycle_done                   (cycle_done),
    .i_halo_push                    (halo_push),
    .i_halo_dir                     (halo_dir),
    .i_halo_row                     (halo_row),
    .i_halo_column                  (halo_column),
    .i_halo_value                   (halo_value),
    .o_halo_full                    (halo_full),
    .i_neighbor_cts                 (cts_in),
    .i_neighbor_exchange_done       (ned_in),
    .o_clear_to_send                (cts_out),
    .o_exchange_done                (exch_done),
    .o_neighbor_output_value        (out_val),
    .o_neighbor_output_row          (out_row),
    .o_neighbor_output_column       (out_col),
    .o_neighbor_output_write_enable (we),
    .o_busy                         (busy),
    .o_group_done                   (group_done),
    .o_overflow                     (overflow),
    .o_timeout                      (timeout)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int dir, input int row, input int col, input int val);
    halo_push   = 1'b1;
    halo_dir    = 3'(dir);
    halo_row    = RW'(row);
    halo_column = RW'(col);
    halo_value  = 8'(val);
    tick();
    halo_push   = 1'b0;
  endtask

  // Full round from IDLE: cycle_done, all CTS, drain, all exchange_done.
  task automatic do_round(input string tag, input int exp_we, output logic [7:0] we_acc);
    int n;
    bit reached;
    n       = 0;
    we_acc  = '0;
    reached = 1'b0;
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    cts_in = 8'hFF;
    tick();
    for (int k = 0; k < 40; k++) begin
      tick();
      n      += $countones(we);
      we_acc |= we;
      if (exch_done) begin
        reached = 1'b1;
        break;
      end
    end
    cts_in = 8'h00;
    chk_eq({tag, "_reach_done"}, 64'(reached), 64'd1);
    chk_eq({tag, "_we_count"}, 64'(n), 64'(exp_we));
    ned_in = 8'hFF;
    #1;
    chk_eq({tag, "_group_done"}, 64'(group_done), 64'd1);
    tick();
    ned_in = 8'h00;
    chk_eq({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] acc;
    int         we_seen;
    int         cts_low;
    int         gd_seen;

    reset = 1'b1; cycle_done = 1'b0; halo_push = 1'b0; halo_dir = '0;
    halo_row = '0; halo_column = '0; halo_value = '0; cts_in = '0; ned_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_eq("rst_busy",     64'(busy), 64'd0);
    chk_eq("rst_cts",      64'(cts_out), 64'd0);
    chk_eq("rst_exch",     64'(exch_done), 64'd0);
    chk_eq("rst_we",       64'(we), 64'd0);
    chk_eq("rst_val",      64'(out_val), 64'd0);
    chk_eq("rst_rowcol",   64'({out_row, out_col}), 64'd0);
    chk_eq("rst_flags",    64'({halo_full, overflow, timeout, group_done}), 64'd0);

    // Basic exchange of three entries.
    push_one(2, 5, 7, 8'h11);
    push_one(0, 1, 1, 8'h22);
    push_one(7, 255, 0, 8'hFF);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    chk_eq("t1_wait_cts", 64'(cts_out), 64'd1);
    chk_eq("t1_wait_busy", 64'(busy), 64'd1);
    cts_in = 8'hFF;
    tick();
    chk_eq("t1_send_we0", 64'(we), 64'd0);
    chk_eq("t1_send_exch", 64'(exch_done), 64'd0);
    tick();
    chk_eq("t1_we_a", 64'(we), 64'h04);
    chk_eq("t1_lane2", 64'({out_val[2], out_row[2], out_col[2]}), 64'h110507);
    tick();
    chk_eq("t1_we_b", 64'(we), 64'h01);
    chk_eq("t1_lane0", 64'({out_val[0], out_row[0], out_col[0]}), 64'h220101);
    chk_eq("t1_exch_b", 64'(exch_done), 64'd0);
    tick();
    cts_in = 8'h00;
    chk_eq("t1_we_c", 64'(we), 64'h80);
    chk_eq("t1_lane7", 64'({out_val[7], out_row[7], out_col[7]}), 64'hFFFF00);
    chk_eq("t1_lane2_kept", 64'(out_val[2]), 64'h11);
    chk_eq("t1_done_exch", 64'(exch_done), 64'd1);
    chk_eq("t1_done_cts", 64'(cts_out), 64'd0);
    chk_eq("t1_gd_wait", 64'(group_done), 64'd0);
    tick();
    chk_eq("t1_we_idle", 64'(we), 64'd0);
    chk_eq("t1_still_done", 64'(exch_done), 64'd1);
    ned_in = 8'hFF;
    #1;
    chk_eq("t1_group_done", 64'(group_done), 64'd1);
    tick();
    chk_eq("t1_gd_pulse", 64'(group_done), 64'd0);
    chk_eq("t1_busy_off", 64'(busy), 64'd0);
    ned_in = 8'h00;

    // Partial CTS holds WAIT_CTS.
    push_one(4, 10, 20, 8'h33);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    cts_in = 8'h7F;
    we_seen = 0;
    cts_low = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (we != 0) we_seen++;
      if (!cts_out) cts_low++;
    end
    chk_eq("t2_no_we", 64'(we_seen), 64'd0);
    chk_eq("t2_cts_held", 64'(cts_low), 64'd0);
    chk_eq("t2_not_done", 64'(exch_done), 64'd0);
    cts_in = 8'hFF;
    tick();
    chk_eq("t2_send_cts", 64'(cts_out), 64'd1);
    chk_eq("t2_send_we", 64'(we), 64'd0);
    tick();
    cts_in = 8'h00;
    chk_eq("t2_we", 64'(we), 64'h10);
    chk_eq("t2_lane4", 64'({out_val[4], out_row[4], out_col[4]}), 64'h330A14);
    chk_eq("t2_done", 64'(exch_done), 64'd1);
    ned_in = 8'hFF;
    tick();
    ned_in = 8'h00;

    // Empty FIFO goes straight through.
    do_round("t3", 0, acc);
    chk_eq("t3_we_acc", 64'(acc), 64'd0);

    // Fill to full, then one more to overflow.
    for (int i = 0; i < 17; i++) begin
      push_one(i % 8, i, 2 * i, 8'h40 + i);
      if (i == 14) chk_eq("t4_not_full_15", 64'(halo_full), 64'd0);
      if (i == 15) begin
        chk_eq("t4_full_16", 64'(halo_full), 64'd1);
        chk_eq("t4_no_ovf_16", 64'(overflow), 64'd0);
      end
    end
    chk_eq("t4_ovf_17", 64'(overflow), 64'd1);
    chk_eq("t4_full_17", 64'(halo_full), 64'd1);
    do_round("t4", 16, acc);
    chk_eq("t4_we_acc", 64'(acc), 64'hFF);
    chk_eq("t4_lane7", 64'(out_val[7]), 64'h4F);
    chk_eq("t4_lane0", 64'(out_val[0]), 64'h48);
    chk_eq("t4_lane3", 64'({out_val[3], out_row[3], out_col[3]}), 64'h4B0B16);
    chk_eq("t4_drained", 64'(halo_full), 64'd0);
    chk_eq("t4_ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-operation.
    push_one(1, 1, 1, 8'h01);
    push_one(2, 2, 2, 8'h02);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_eq("rst2_busy", 64'(busy), 64'd0);
    chk_eq("rst2_cts", 64'(cts_out), 64'd0);
    chk_eq("rst2_ovf", 64'(overflow), 64'd0);
    chk_eq("rst2_val", 64'(out_val), 64'd0);
    do_round("rst2", 0, acc);

    // Push during SEND waits for the next round.
    push_one(1, 2, 3, 8'h61);
    push_one(3, 4, 5, 8'h62);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    cts_in = 8'hFF;
    tick();
    cts_in = 8'h00;
    halo_push = 1'b1; halo_dir = 3'd5; halo_row = 8'd6; halo_column = 8'd7; halo_value = 8'h63;
    tick();
    halo_push = 1'b0;
    chk_eq("t5_we_a", 64'(we), 64'h02);
    tick();
    chk_eq("t5_we_b", 64'(we), 64'h08);
    chk_eq("t5_lane3", 64'(out_val[3]), 64'h62);
    chk_eq("t5_done", 64'(exch_done), 64'd1);
    tick();
    chk_eq("t5_we_none", 64'(we), 64'd0);
    ned_in = 8'hFF;
    tick();
    ned_in = 8'h00;
    do_round("t5b", 1, acc);
    chk_eq("t5b_we_acc", 64'(acc), 64'h20);
    chk_eq("t5b_lane5", 64'({out_val[5], out_row[5], out_col[5]}), 64'h630607);

`ifdef PPU_EXCHANGE_TIMEOUT_EN
    // Watchdog expiry in WAIT_CTS.
    push_one(6, 9, 9, 8'h77);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    gd_seen = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (group_done) gd_seen++;
    end
    chk_eq("t6_busy_8th", 64'(busy), 64'd1);
    chk_eq("t6_to_pre", 64'(timeout), 64'd0);
    tick();
    if (group_done) gd_seen++;
    chk_eq("t6_idle", 64'(busy), 64'd0);
    chk_eq("t6_timeout", 64'(timeout), 64'd1);
    chk_eq("t6_no_gd", 64'(gd_seen), 64'd0);
    do_round("t6", 0, acc);
    chk_eq("t6_sticky", 64'(timeout), 64'd1);
`else
    // Without the watchdog a long WAIT_CTS never times out.
    push_one(6, 9, 9, 8'h77);
    cycle_done = 1'b1;
    tick();
    cycle_done = 1'b0;
    gd_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (group_done) gd_seen++;
    end
    chk_eq("t6_busy", 64'(busy), 64'd1);
    chk_eq("t6_timeout", 64'(timeout), 64'd0);
    chk_eq("t6_no_gd", 64'(gd_seen), 64'd0);
    cts_in = 8'hFF;
    tick();
    cts_in = 8'h00;
    tick();
    chk_eq("t6_we", 64'(we), 64'h40);
    ned_in = 8'hFF;
    tick();
    ned_in = 8'h00;
    chk_eq("t6_idle", 64'(busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppu_exchange_ctrl.md
Name: ppu_exchange_ctrl

Overview:
- Sequences the per-tile neighbor halo exchange for one PPU.
- The PPU pushes partial outputs that land outside its tile into a halo FIFO, tagged by neighbor direction.
- After the local compute cycle completes, this block runs the handshake with the 8 neighbors (clear_to_send / neighbor_cts, exchange_done / neighbor_exchange_done), then drains the FIFO onto the per-neighbor write ports.
- It sits between the PPU compute pipeline and the neighbor links.

Parameters:
- TILE_SIZE, 256, tile dimension; coordinate width RW = $clog2(TILE_SIZE).
- FIFO_DEPTH, 16, halo FIFO entries (power of 2).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cycle_done  in  1  pulse: local compute for the current tile finished
- halo_push  in  1  push one halo entry
- halo_dir  in  3  target neighbor, 0..7 = N,NE,E,SE,S,SW,W,NW
- halo_row  in  RW  row in the neighbor's coordinates
- halo_column  in  RW  column in the neighbor's coordinates
- halo_value  in  8  partial value
- halo_full  out  1  FIFO full
- neighbor_cts  in  8  per-neighbor clear-to-send
- neighbor_exchange_done  in  8  per-neighbor exchange finished
- clear_to_send  out  1  this PPU is ready to exchange
- exchange_done  out  1  this PPU has finished sending
- neighbor_output_value  out  8x8  per-neighbor value
- neighbor_output_row  out  8xRW  per-neighbor row
- neighbor_output_column  out  8xRW  per-neighbor column
- neighbor_output_write_enable  out  8  per-neighbor write strobe
- busy  out  1  state != IDLE
- group_done  out  1  one-cycle pulse when the exchange completes
- overflow  out  1  sticky: a push was dropped because the FIFO was full
- timeout  out  1  sticky; held 0 when the optional feature is out

Behaviour:
- Reset: state IDLE, FIFO empty; all outputs 0, including the value/row/column arrays and the sticky flags.
- The FIFO accepts a push in any state. A push while full (and no simultaneous pop) is dropped and sets overflow. Push and pop in the same cycle while full is legal.
- halo_full = (count == FIFO_DEPTH).
- IDLE:
  - cycle_done=1 -> WAIT_CTS.
  - cycle_done in any other state is ignored.
- WAIT_CTS:
  - clear_to_send=1.
  - When neighbor_cts == 8'hFF (sampled), snapshot drain_cnt = FIFO count that cycle -> SEND.
- SEND:
  - clear_to_send stays 1.
  - Each cycle with drain_cnt != 0: pop the head and decrement drain_cnt.
  - Next cycle (1-cycle registered latency), neighbor_output_write_enable[dir]=1 and only that bit. The value/row/column for lane dir are updated.
  - Other lanes keep their previous data with write_enable 0.
  - When drain_cnt == 0 (including entry with 0) -> DONE. The final write strobe is still emitted in the first DONE cycle.
  - Entries pushed during SEND or later stay in the FIFO for the next round.
- DONE:
  - exchange_done=1, clear_to_send=0.
  - When neighbor_exchange_done == 8'hFF -> IDLE, with group_done=1 for exactly that transition cycle.
- Outside the cycle following a pop, neighbor_output_write_enable = 0.
- Reset asserted mid-operation: FIFO flushed, state IDLE, sticky flags cleared, all handshake outputs 0 on the next edge.

Optional Feature:
- PPU_EXCHANGE_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT_CTS or DONE, and clears on entering either state.
  - Reaching TIMEOUT_CYCLES sets timeout (sticky), flushes the FIFO and forces IDLE.
  - group_done does not pulse on a timeout exit.
- Undefined: no counter; timeout is tied to 0.

Decomposition:
- Package ppu_exch_pkg holds:
  - the direction enum (N..NW = 0..7);
  - the state enum {IDLE, WAIT_CTS, SEND, DONE};
  - the halo entry struct {dir, row, column, value};
  - localparam NEIGHBOR_COUNT = 8.
- Sub-module halo_fifo: synchronous FIFO of halo entries with push/pop, count, full and empty outputs.

Test Plan:
- Reset, then push 3 entries (dir 2 r5 c7 v0x11; dir 0 r1 c1 v0x22; dir 7 r255 c0 v0xFF), then cycle_done, then cts=FF. Required: write_enable 8'h04, 8'h01, 8'h80 on consecutive cycles with matching data; then exchange_done=1; done=FF gives group_done for one cycle, busy=0.
- cycle_done with cts=8'h7F held for 50 cycles. Required: no strobes and clear_to_send=1 throughout; raising bit 7 starts SEND on the next edge.
- Empty FIFO, then cycle_done, then cts=FF. Required: straight to DONE, zero write strobes.
- 17 pushes with no pops. Required: halo_full after the 16th push, overflow=1 after the 17th; 16 strobes are emitted in the next exchange.
- A push arrives during SEND with 2 entries snapshotted. Required: exactly 2 strobes this round, and the new entry is sent in the next round.
- With PPU_EXCHANGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, cts held at 0. Required: timeout=1 and IDLE after 8 WAIT_CTS cycles, FIFO empty, no group_done.
